timer_irq_controller: RTL

- Programmable interval timer feeding the interrupt input of the pipelined CPU; replaces free-running divided clocks with a single-clock-domain tick enable.
- The CPU configures it through a small memory-mapped register port (reload value, mode, enable).
- It raises a level interrupt request on expiry, which the CPU clears by acknowledge or write-1-to-clear.
- Tracks missed interrupts when expiry occurs while a request is still pending.

---
 rtl/timer_irq_controller_pkg.sv | 27 ++
 rtl/timer_irq_controller_tick_prescaler.sv | 31 +++
 rtl/timer_irq_controller.sv | 127 ++++++++++++
 3 files changed

// File: rtl/timer_irq_controller_pkg.sv
// Shared register map, bit positions and state encoding for the interval timer.
package timer_irq_controller_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned MISS_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_LOAD   = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN         = 0;
    localparam int unsigned CTRL_AUTO       = 1;
    localparam int unsigned STATUS_PEND     = 0;
    localparam int unsigned STATUS_MISS_CLR = 1;
    localparam int unsigned STATUS_MISS_LSB = 8;

    localparam logic [MISS_W-1:0] MISS_MAX = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_irq_controller_tick_prescaler.sv
// Divides the system clock into a one-cycle tick enable every PRESCALE clocks while running.
module timer_irq_controller_tick_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Run,
    input  logic Clear,
    output logic Tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;
    logic             at_last;

    assign at_last = (count == LAST);

    always_ff @(posedge Clock) begin
        if (Reset || !Run || Clear || at_last) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // No tick may escape while reset is being applied.
    assign Tick = Run && !Reset && at_last;

endmodule

// File: rtl/timer_irq_controller.sv
// Interval timer with register port, level IRQ and missed-expiry counter.
module timer_irq_controller
    import timer_irq_controller_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned WIDTH    = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [REG_W-1:0]  WriteData,
    output logic [REG_W-1:0]  ReadData,
    input  logic              IntAck,
    output logic              IRQ,
    output logic              Tick
);

    state_t             state;
    logic               ctrl_auto;
    logic [WIDTH-1:0]   load;
    logic [WIDTH-1:0]   count;
    logic               pending;
    logic [MISS_W-1:0]  miss_count;
    logic [REG_W-1:0]   read_data;
    logic [REG_W-1:0]   rd_mux;
    logic               tick;

    logic ctrl_wr, load_wr, status_wr;
    logic start, stop, expire, pend_clr, miss_clr, running;

    assign running   = (state == ST_RUN);
    assign ctrl_wr   = WriteEnable && (Addr == ADDR_CTRL);
    assign load_wr   = WriteEnable && (Addr == ADDR_LOAD);
    assign status_wr = WriteEnable && (Addr == ADDR_STATUS);
    assign start     = ctrl_wr && WriteData[CTRL_EN] && !running;
    assign stop      = ctrl_wr && !WriteData[CTRL_EN];
    assign expire    = running && tick && !stop && (count <= WIDTH'(1));
    assign pend_clr  = IntAck || (status_wr && WriteData[STATUS_PEND]);
    assign miss_clr  = status_wr && WriteData[STATUS_MISS_CLR];

    timer_irq_controller_tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .Clock (Clock),
        .Reset (Reset),
        .Run   (running),
        .Clear (start),
        .Tick  (tick)
    );

    // Read view of the registers as they stand before this cycle's write.
    always_comb begin
        rd_mux = '0;
        case (Addr)
            ADDR_CTRL: begin
                rd_mux[CTRL_EN]   = running;
                rd_mux[CTRL_AUTO] = ctrl_auto;
            end
            ADDR_LOAD:  rd_mux = REG_W'(load);
            ADDR_COUNT: rd_mux = REG_W'(count);
            default: begin
                rd_mux[STATUS_PEND]                    = pending;
                rd_mux[STATUS_MISS_LSB +: MISS_W]      = miss_count;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= ST_IDLE;
            ctrl_auto  <= 1'b0;
            load       <= '0;
            count      <= '0;
            pending    <= 1'b0;
            miss_count <= '0;
            read_data  <= '0;
        end else begin
            read_data <= rd_mux;
            if (load_wr) load <= WriteData[WIDTH-1:0];
            if (ctrl_wr) ctrl_auto <= WriteData[CTRL_AUTO];

            case (state)
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end else if (ctrl_auto) begin
                            count <= load;
                        end else begin
                            count <= '0;
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state <= ST_RUN;
                        count <= load;
                    end else if (stop) begin
                        state <= ST_IDLE;
                    end
                end
            endcase

            // A fresh expiry outranks a clear; a clear of the miss counter outranks an increment.
            if (expire) begin
                pending <= 1'b1;
            end else if (pend_clr) begin
                pending <= 1'b0;
            end

            if (miss_clr) begin
                miss_count <= '0;
            end else if (expire && pending && !pend_clr && (miss_count != MISS_MAX)) begin
                miss_count <= miss_count + MISS_W'(1);
            end
        end
    end

    assign IRQ      = pending;
    assign ReadData = read_data;
    assign Tick     = tick;

endmodule
